// File: rtl/serial_adder_fsm.sv
// Bit-serial add/subtract engine: one decoder-based full adder processes one
// operand bit per clock, LSB first, and reports sum, carry-out and overflow.

module full_adder_decoder_gate (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);
  logic a_n, b_n, cin_n;
  logic [7:1] m;

  assign a_n   = ~a;
  assign b_n   = ~b;
  assign cin_n = ~cin;

  // 3-to-8 minterm decoder indexed by {a, b, cin}; minterm 0 drives no output
  assign m[1] = a_n & b_n & cin;
  assign m[2] = a_n & b   & cin_n;
  assign m[3] = a_n & b   & cin;
  assign m[4] = a   & b_n & cin_n;
  assign m[5] = a   & b_n & cin;
  assign m[6] = a   & b   & cin_n;
  assign m[7] = a   & b   & cin;

  assign s = m[1] | m[2] | m[4] | m[7];
  assign c = m[3] | m[5] | m[6] | m[7];
endmodule

// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one operand bit per clock through the full adder
// DONE  | single-cycle done pulse, then back to IDLE
module serial_adder_fsm #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic fa_s, fa_c;

  full_adder_decoder_gate u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction as A + ~B + 1: the +1 enters as the initial carry
          state_d = S_SHIFT;
          a_sr_d  = a_in;
          b_sr_d  = sub ? ~b_in : b_in;
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        result_d = {fa_s, result_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ fa_c;
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: directed corner cases plus
// randomized operations against an integer-arithmetic reference model.

module tb_serial_adder_fsm;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  // Reference: {ovf, cout, result} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    int ua, ub, sa, sb, ex_u, ex_s;
    logic [W-1:0] r;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    ex_u = s ? ua - ub : ua + ub;
    ex_s = s ? sa - sb : sa + sb;
    r = ex_u[W-1:0];
    c = s ? (ua >= ub) : (ex_u >= (1 << W));
    o = (ex_s > ((1 << (W-1)) - 1)) || (ex_s < -(1 << (W-1)));
    return {o, c, r};
  endfunction

  // Runs one operation; lat = cycles from start edge to done (0 if it never came)
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic o,
                       output int lat, output int busy_n, output int done_n);
    r = '0; c = 1'b0; o = 1'b0; lat = 0; busy_n = 0; done_n = 0;
    @(negedge clk);
    a_in = a; b_in = b; sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); sub = 1'($urandom);
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        if (done_n == 0) begin
          lat = i + 1; r = result; c = cout; o = ovf;
        end
        done_n++;
      end else if (done_n > 0) begin
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, cout, ovf, result} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b ovf=%b result=%h want all 0",
               busy, done, cout, ovf, result);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] r; logic c, o; int lat, bn, dn;
    do_op(8'h3C, 8'h0F, 1'b0, r, c, o, lat, bn, dn);
    n_cmp++;
    if (lat !== W + 1) begin n_bad++; $display("FAIL add_latency: got %0d want %0d", lat, W + 1); end
    n_cmp++;
    if (bn !== W) begin n_bad++; $display("FAIL add_busy_cycles: got %0d want %0d", bn, W); end
    n_cmp++;
    if (dn !== 1) begin n_bad++; $display("FAIL add_done_width: got %0d want 1", dn); end
    n_cmp++;
    if ({o, c, r} !== {1'b0, 1'b0, 8'h4B}) begin
      n_bad++; $display("FAIL add_3c_0f: got ovf=%b cout=%b r=%h want 0 0 4b", o, c, r);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (result !== 8'h4B) begin n_bad++; $display("FAIL add_hold: got %h want 4b", result); end

    do_op(8'hFF, 8'h01, 1'b0, r, c, o, lat, bn, dn);
    n_cmp++;
    if ({o, c, r} !== {1'b0, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL add_ff_01: got ovf=%b cout=%b r=%h want 0 1 00", o, c, r);
    end
    do_op(8'h7F, 8'h01, 1'b0, r, c, o, lat, bn, dn);
    n_cmp++;
    if ({o, c, r} !== {1'b1, 1'b0, 8'h80}) begin
      n_bad++; $display("FAIL add_7f_01: got ovf=%b cout=%b r=%h want 1 0 80", o, c, r);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] r; logic c, o; int lat, bn, dn;
    do_op(8'h05, 8'h07, 1'b1, r, c, o, lat, bn, dn);
    n_cmp++;
    if ({o, c, r} !== {1'b0, 1'b0, 8'hFE}) begin
      n_bad++; $display("FAIL sub_05_07: got ovf=%b cout=%b r=%h want 0 0 fe", o, c, r);
    end
    do_op(8'h80, 8'h01, 1'b1, r, c, o, lat, bn, dn);
    n_cmp++;
    if ({o, c, r} !== {1'b1, 1'b1, 8'h7F}) begin
      n_bad++; $display("FAIL sub_80_01: got ovf=%b cout=%b r=%h want 1 1 7f", o, c, r);
    end
  endtask

  task automatic test_ignore_start();
    int lat, dn, late_busy;
    logic [W-1:0] r;
    lat = 0; dn = 0; late_busy = 0; r = '0;
    @(negedge clk);
    a_in = 8'h3C; b_in = 8'h0F; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        if (dn == 0) begin lat = 4 + i + 1; r = result; end
        dn++;
      end else if (dn > 0 && busy) begin
        late_busy++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (dn !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
    n_cmp++;
    if (lat !== W + 1) begin n_bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, W + 1); end
    n_cmp++;
    if (r !== 8'h4B) begin n_bad++; $display("FAIL ignore_result: got %h want 4b", r); end
    n_cmp++;
    if (late_busy !== 0) begin n_bad++; $display("FAIL ignore_no_restart: got %0d busy cycles want 0", late_busy); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] r; logic c, o; int lat, bn, dn, stray;
    @(negedge clk);
    a_in = 8'h5A; b_in = 8'h33; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b1 || result === 8'h00) begin
      n_bad++; $display("FAIL areset_pre: got busy=%b result=%h want busy=1 result nonzero", busy, result);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, result} !== '0) begin
      n_bad++; $display("FAIL areset_immediate: got busy=%b done=%b result=%h want 0 0 00", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) stray++;
      @(negedge clk);
    end
    n_cmp++;
    if (stray !== 0) begin n_bad++; $display("FAIL areset_no_done: got %0d active cycles want 0", stray); end
    do_op(8'h01, 8'h01, 1'b0, r, c, o, lat, bn, dn);
    n_cmp++;
    if ({lat, o, c, r} !== {W + 1, 1'b0, 1'b0, 8'h02}) begin
      n_bad++; $display("FAIL areset_after: got lat=%0d ovf=%b cout=%b r=%h want %0d 0 0 02", lat, o, c, r, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [W-1:0] qa[N];
    logic [W-1:0] qb[N];
    logic         qs[N];
    logic [W+1:0] exp_v;
    int k, nxt, prev;
    for (int i = 0; i < N; i++) begin
      qa[i] = W'($urandom); qb[i] = W'($urandom); qs[i] = 1'($urandom);
    end
    k = 0; nxt = 1; prev = 0;
    @(negedge clk);
    a_in = qa[0]; b_in = qb[0]; sub = qs[0]; start = 1'b1;
    for (int i = 0; i < N * (W + 2) + 30; i++) begin
      @(negedge clk);
      if (done) begin
        exp_v = model(qa[k], qb[k], qs[k]);
        n_cmp++;
        if ({ovf, cout, result} !== exp_v) begin
          n_bad++; $display("FAIL b2b_op%0d: got %b_%b_%h want %b_%b_%h", k, ovf, cout, result,
                            exp_v[W+1], exp_v[W], exp_v[W-1:0]);
        end
        if (k > 0) begin
          n_cmp++;
          if (i - prev !== W + 2) begin
            n_bad++; $display("FAIL b2b_period%0d: got %0d want %0d", k, i - prev, W + 2);
          end
        end
        prev = i;
        k++;
        if (nxt < N) begin
          a_in = qa[nxt]; b_in = qb[nxt]; sub = qs[nxt]; nxt++;
        end
        if (k == N) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (k !== N) begin n_bad++; $display("FAIL b2b_count: got %0d done pulses want %0d", k, N); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r; logic s, c, o; logic [W+1:0] exp_v; int lat, bn, dn;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      if (i == 0) begin a = '0; b = '0; s = 1'b1; end
      exp_v = model(a, b, s);
      do_op(a, b, s, r, c, o, lat, bn, dn);
      n_cmp++;
      if ({lat, o, c, r} !== {W + 1, exp_v}) begin
        n_bad++; $display("FAIL rand%0d %h%s%h: got lat=%0d %b_%b_%h want %0d %b_%b_%h", i, a,
                          s ? "-" : "+", b, lat, o, c, r, W + 1, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
- Bit-serial add/subtract engine built around one instance of the team's decoder-based gate-level full adder (full_adder_decoder_gate).
- Loads two WIDTH-bit operands on a start pulse and feeds the full adder one bit per clock, LSB first.
- Registers the adder's C output as the next cycle's Cin, and shifts the adder's S output into a result register.
- Reports the sum, carry-out and signed overflow with a one-cycle done pulse. It trades latency for area in small datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B; captured with the operands at start.
- a_in  input  WIDTH  operand A, captured at start.
- b_in  input  WIDTH  operand B, captured at start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when result, cout and ovf are valid.
- result  output  WIDTH  sum/difference; held stable from done until the next accepted start.
- cout  output  1  final carry out; in subtract mode 1 = no borrow.
- ovf  output  1  two's-complement overflow of the operation.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-high, on rst.
- Reset values:
  - state = IDLE.
  - busy, done, cout and ovf = 0; result = 0.
  - Operand shift registers, carry FF and counter = 0.
- States:
  - IDLE: waits for start.
  - SHIFT: processes one bit per cycle.
  - DONE: one cycle, asserts done.
- IDLE -> SHIFT on a rising edge with start=1:
  - a_sr <= a_in.
  - b_sr <= sub ? ~b_in : b_in.
  - carry <= sub.
  - cnt <= 0.
- IDLE with start=0: no change; outputs hold their previous values.
- SHIFT, each edge:
  - The full adder sees A=a_sr[0], B=b_sr[0], Cin=carry.
  - The result register shifts right, with S entering at bit WIDTH-1.
  - a_sr and b_sr shift right.
  - carry <= C.
  - cnt <= cnt+1.
- SHIFT at cnt == WIDTH-1:
  - Additionally, ovf <= carry XOR C, i.e. the carry into the MSB XOR the carry out of the MSB.
  - cout <= C.
  - state <= DONE.
- DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- Timing: busy and done are Moore outputs (busy = state==SHIFT, done = state==DONE). Counting the accepting edge as edge 0:
  - busy is high between edges 0 and WIDTH.
  - done is high between edges WIDTH and WIDTH+1.
  - Total latency from start sample to done = WIDTH+1 cycles.
- start asserted in SHIFT or DONE is ignored (no queuing). It must be re-presented in IDLE.
- Operands are taken only from the start edge. Changes to a_in/b_in/sub afterwards have no effect on the operation in flight.
- result, cout and ovf change only during SHIFT.
  - They equal partial values while busy=1.
  - The bench checks them only at done or later.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No done is produced for the aborted operation.
- The arithmetic is modulo 2^WIDTH. cout is the raw carry out of bit WIDTH-1.

Test Plan (WIDTH=8):
- Add 0x3C+0x0F (sub=0) -> done 9 cycles after start; result=0x4B, cout=0, ovf=0; busy high for exactly 8 cycles.
- Add 0xFF+0x01 -> result=0x00, cout=1, ovf=0. Then 0x7F+0x01 -> result=0x80, cout=0, ovf=1.
- Subtract 0x05-0x07 (sub=1) -> result=0xFE, cout=0 (borrow), ovf=0. Then 0x80-0x01 -> result=0x7F, cout=1, ovf=1.
- Pulse start again 3 cycles into an operation with different operands -> ignored; the first result completes unchanged; exactly one done pulse.
- Assert rst asynchronously mid-SHIFT (cnt=4) -> busy, done and result drop to 0 without waiting for a clock edge. A start after release runs normally, e.g. 0x01+0x01 gives 0x02.
- Back-to-back: start held high continuously -> a new operation is accepted on the first edge after done, i.e. one done every WIDTH+2 cycles; results stay correct for randomized operands versus a reference model.
